// File: rtl/multiplier_leak_checker.sv
// multiplier_leak_checker
// Runs CHANNELS shift-add multipliers in parallel and reports whether they
// finish on different cycles. A spread between the first and last channel
// completion means the iteration count depends on operand values, which is
// a timing leak.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; operands, accumulators and mode load on start
// RUN    | channels iterate one shift-add per cycle until each completes
// REPORT | one cycle: done pulses, spread/leak/sticky/count already updated
module multiplier_leak_checker #(
  parameter int WIDTH     = 4,
  parameter int CHANNELS  = 2,
  parameter int CNT_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          const_mode,
  input  logic [CHANNELS*WIDTH-1:0]     multiplier,
  input  logic [CHANNELS*WIDTH-1:0]     multiplicand,
  output logic [CHANNELS*2*WIDTH-1:0]   product,
  output logic                          busy,
  output logic                          done,
  output logic                          leak,
  output logic                          leak_sticky,
  output logic [$clog2(WIDTH+1)-1:0]    spread,
  output logic [CNT_WIDTH-1:0]          leak_count
);

  // Wide enough for an iteration count or cycle index of 0..WIDTH.
  localparam int IW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Per-channel datapath
  logic [WIDTH-1:0]   mplier_q [CHANNELS];
  logic [WIDTH-1:0]   mplier_d [CHANNELS];
  logic [2*WIDTH-1:0] mcand_q  [CHANNELS];
  logic [2*WIDTH-1:0] mcand_d  [CHANNELS];
  logic [2*WIDTH-1:0] acc_q    [CHANNELS];
  logic [2*WIDTH-1:0] acc_d    [CHANNELS];
  logic [2*WIDTH-1:0] acc_nx   [CHANNELS];
  logic [2*WIDTH-1:0] prod_q   [CHANNELS];
  logic [2*WIDTH-1:0] prod_d   [CHANNELS];
  logic [IW-1:0]      rem_q    [CHANNELS];
  logic [IW-1:0]      rem_d    [CHANNELS];
  logic [CHANNELS-1:0] cdone_q, cdone_d;
  logic [CHANNELS-1:0] cmode_q, cmode_d;

  // Run timing and report state
  logic [IW-1:0]        cyc_q, cyc_d;
  logic [IW-1:0]        first_q, first_d;
  logic [IW-1:0]        last_q, last_d;
  logic                 first_vld_q, first_vld_d;
  logic [IW-1:0]        spread_q, spread_d;
  logic                 leak_q, leak_d;
  logic                 sticky_q, sticky_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic start_acc;
  logic all_done;
  logic any_done_now;
  logic enter_report;

  // Iterations a channel needs: full width in constant-time mode, otherwise
  // just enough to consume the highest set multiplier bit (at least one).
  function automatic logic [IW-1:0] iter_count(input logic [WIDTH-1:0] m,
                                               input logic             cm);
    logic [IW-1:0] n;
    n = IW'(1);
    if (cm) begin
      n = IW'(WIDTH);
    end else begin
      for (int b = 0; b < WIDTH; b++) begin
        if (m[b]) n = IW'(b + 1);
      end
    end
    return n;
  endfunction

  assign start_acc    = (state_q == S_IDLE) && start;
  assign all_done     = &cdone_q;
  assign enter_report = (state_q == S_RUN) && all_done;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; start outside IDLE is simply not looked at
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start)    state_d = S_RUN;
      S_RUN:    if (all_done) state_d = S_REPORT;
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      S_RUN:    busy = 1'b1;
      S_REPORT: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Channel iteration: load on start, one shift-add per RUN cycle, latch
  // the product on the final iteration and freeze until the next start.
  always_comb begin
    any_done_now = 1'b0;
    cdone_d      = cdone_q;
    cmode_d      = cmode_q;
    for (int c = 0; c < CHANNELS; c++) begin
      mplier_d[c] = mplier_q[c];
      mcand_d[c]  = mcand_q[c];
      acc_d[c]    = acc_q[c];
      prod_d[c]   = prod_q[c];
      rem_d[c]    = rem_q[c];
      acc_nx[c]   = acc_q[c] + (mplier_q[c][0] ? mcand_q[c] : '0);
      if (start_acc) begin
        mplier_d[c] = multiplier[c*WIDTH +: WIDTH];
        mcand_d[c]  = {{WIDTH{1'b0}}, multiplicand[c*WIDTH +: WIDTH]};
        acc_d[c]    = '0;
        rem_d[c]    = iter_count(multiplier[c*WIDTH +: WIDTH], const_mode);
        cdone_d[c]  = 1'b0;
        cmode_d[c]  = const_mode;
      end else if ((state_q == S_RUN) && !cdone_q[c]) begin
        acc_d[c]    = acc_nx[c];
        mplier_d[c] = mplier_q[c] >> 1;
        mcand_d[c]  = mcand_q[c] << 1;
        rem_d[c]    = rem_q[c] - IW'(1);
        if (rem_q[c] == IW'(1)) begin
          cdone_d[c]   = 1'b1;
          prod_d[c]    = acc_nx[c];
          any_done_now = 1'b1;
        end
      end
    end
  end

  // Channel registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdone_q <= '0;
      cmode_q <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        mplier_q[c] <= '0;
        mcand_q[c]  <= '0;
        acc_q[c]    <= '0;
        prod_q[c]   <= '0;
        rem_q[c]    <= '0;
      end
    end else begin
      cdone_q <= cdone_d;
      cmode_q <= cmode_d;
      for (int c = 0; c < CHANNELS; c++) begin
        mplier_q[c] <= mplier_d[c];
        mcand_q[c]  <= mcand_d[c];
        acc_q[c]    <= acc_d[c];
        prod_q[c]   <= prod_d[c];
        rem_q[c]    <= rem_d[c];
      end
    end
  end

  // Run cycle counter and first/last completion stamps; the counter stops
  // once every channel is finished so it never wraps for small WIDTH.
  always_comb begin
    cyc_d       = cyc_q;
    first_d     = first_q;
    last_d      = last_q;
    first_vld_d = first_vld_q;
    if (start_acc) begin
      cyc_d       = '0;
      first_d     = '0;
      last_d      = '0;
      first_vld_d = 1'b0;
    end else if ((state_q == S_RUN) && !all_done) begin
      cyc_d = cyc_q + IW'(1);
      if (any_done_now) begin
        last_d = cyc_q + IW'(1);
        if (!first_vld_q) begin
          first_d     = cyc_q + IW'(1);
          first_vld_d = 1'b1;
        end
      end
    end
  end

  // Leak verdict is formed on the RUN->REPORT edge and held until the next
  // report; the sticky flag and the saturating count only move on a leak.
  always_comb begin
    spread_d = spread_q;
    leak_d   = leak_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (enter_report) begin
      spread_d = last_q - first_q;
      leak_d   = (last_q != first_q);
      if (last_q != first_q) begin
        sticky_d = 1'b1;
        if (cnt_q != {CNT_WIDTH{1'b1}}) cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // Timing and report registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q       <= '0;
      first_q     <= '0;
      last_q      <= '0;
      first_vld_q <= 1'b0;
      spread_q    <= '0;
      leak_q      <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      cyc_q       <= cyc_d;
      first_q     <= first_d;
      last_q      <= last_d;
      first_vld_q <= first_vld_d;
      spread_q    <= spread_d;
      leak_q      <= leak_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
    end
  end

  // Flatten latched products onto the output bus
  always_comb begin
    product = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      product[c*2*WIDTH +: 2*WIDTH] = prod_q[c];
    end
  end

  assign spread      = spread_q;
  assign leak        = leak_q;
  assign leak_sticky = sticky_q;
  assign leak_count  = cnt_q;

endmodule

// File: tb/tb_multiplier_leak_checker.sv
// Bench for multiplier_leak_checker (WIDTH=4, CHANNELS=2, CNT_WIDTH=2 so the
// saturating counter is reached quickly).
module tb_multiplier_leak_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       const_mode;
  logic [7:0] multiplier;
  logic [7:0] multiplicand;
  logic [15:0] product;
  logic       busy, done, leak, leak_sticky;
  logic [2:0] spread;
  logic [1:0] leak_count;

  int vec   = 0;
  int fails = 0;

  // reference model state
  logic [7:0] prevp [2];
  bit         m_sticky;
  int         m_cnt;
  bit         m_leak;
  int         m_spread;

  multiplier_leak_checker #(.WIDTH(4), .CHANNELS(2), .CNT_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .start(start), .const_mode(const_mode),
    .multiplier(multiplier), .multiplicand(multiplicand),
    .product(product), .busy(busy), .done(done), .leak(leak),
    .leak_sticky(leak_sticky), .spread(spread), .leak_count(leak_count)
  );

  always #5 clk = ~clk;

  // Iterations a channel needs, from the operand value alone.
  function automatic int n_iter(input int m, input bit cm);
    int n;
    int v;
    if (cm) return 4;
    n = 0;
    v = m;
    while (v != 0) begin
      n++;
      v = v / 2;
    end
    return (n == 0) ? 1 : n;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; const_mode = 1'b0;
    multiplier = 8'h00; multiplicand = 8'h00;
    #12;
    vec++;
    if ({product, busy, done, leak, leak_sticky, spread, leak_count} !== 25'd0) begin
      fails++;
      $display("FAIL reset_outputs: got prod=%h busy=%b done=%b leak=%b sticky=%b spread=%0d cnt=%0d, want all 0",
               product, busy, done, leak, leak_sticky, spread, leak_count);
    end
    @(negedge clk); rst = 1'b0;
    prevp[0] = 8'd0; prevp[1] = 8'd0;
    m_sticky = 1'b0; m_cnt = 0; m_leak = 1'b0; m_spread = 0;
  endtask

  // One full run, checked cycle by cycle against the model. With poke set,
  // start is pulsed once while the DUT is busy and must be ignored.
  task automatic run_check(input logic [7:0] m, input logic [7:0] a,
                           input logic cm, input bit poke);
    int n [2];
    logic [7:0] newp [2];
    int nmax, nmin, lat, poke_at;
    logic [7:0] ep;
    for (int i = 0; i < 2; i++) begin
      n[i]    = n_iter(int'(m[i*4 +: 4]), cm);
      newp[i] = 8'(int'(m[i*4 +: 4]) * int'(a[i*4 +: 4]));
    end
    nmax = (n[0] > n[1]) ? n[0] : n[1];
    nmin = (n[0] < n[1]) ? n[0] : n[1];
    lat  = nmax + 1;
    poke_at = $urandom_range(1, lat);

    @(negedge clk);
    multiplier = m; multiplicand = a; const_mode = cm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    multiplier = 8'($urandom); multiplicand = 8'($urandom); const_mode = ~cm;

    for (int j = 1; j <= lat + 2; j++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (j == lat) begin
        m_spread = nmax - nmin;
        m_leak   = (m_spread != 0);
        if (m_leak) begin
          m_sticky = 1'b1;
          if (m_cnt < 3) m_cnt++;
        end
      end
      for (int i = 0; i < 2; i++) begin
        ep = (j >= n[i]) ? newp[i] : prevp[i];
        vec++;
        if (product[i*8 +: 8] !== ep) begin
          fails++;
          $display("FAIL product_ch%0d cyc%0d: got %0d want %0d (m=%h a=%h cm=%b)",
                   i, j, product[i*8 +: 8], ep, m, a, cm);
        end
      end
      vec++;
      if (done !== (j == lat) || busy !== (j <= lat)) begin
        fails++;
        $display("FAIL done_busy cyc%0d: got done=%b busy=%b want done=%b busy=%b (m=%h cm=%b)",
                 j, done, busy, (j == lat), (j <= lat), m, cm);
      end
      if (j >= lat) begin
        vec++;
        if (spread !== 3'(m_spread) || leak !== m_leak ||
            leak_sticky !== m_sticky || leak_count !== 2'(m_cnt)) begin
          fails++;
          $display("FAIL report cyc%0d: got spread=%0d leak=%b sticky=%b cnt=%0d want %0d %b %b %0d (m=%h cm=%b)",
                   j, spread, leak, leak_sticky, leak_count,
                   m_spread, m_leak, m_sticky, m_cnt, m, cm);
        end
      end
      if (poke && j == poke_at) start = 1'b1;
    end
    start = 1'b0;
    prevp[0] = newp[0]; prevp[1] = newp[1];
  endtask

  task automatic test_const_mode();
    run_check({4'd0, 4'd3}, {4'd9, 4'd5}, 1'b1, 1'b0);
    run_check(8'hFF, 8'hFF, 1'b1, 1'b0);
    run_check(8'hFF, 8'hFF, 1'b0, 1'b0);
    run_check({4'd8, 4'd1}, {4'd7, 4'd7}, 1'b1, 1'b0);
  endtask

  task automatic test_early_term();
    run_check({4'd8, 4'd1}, {4'd7, 4'd7}, 1'b0, 1'b0);
    run_check(8'h00, 8'hA5, 1'b0, 1'b0);
    run_check({4'd2, 4'd3}, {4'd6, 4'd4}, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 5; r++) begin
      run_check({4'd8, 4'd1}, 8'($urandom), 1'b0, 1'b1);
    end
    vec++;
    if (leak_count !== 2'd3) begin
      fails++;
      $display("FAIL count_saturate: got %0d want 3", leak_count);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 30; r++) begin
      run_check(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_reset_mid_run();
    bit saw_done;
    run_check({4'd8, 4'd1}, {4'd7, 4'd7}, 1'b0, 1'b0);
    @(negedge clk);
    multiplier = 8'h9D; multiplicand = 8'h3C; const_mode = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    vec++;
    if ({product, busy, done, leak, leak_sticky, spread, leak_count} !== 25'd0) begin
      fails++;
      $display("FAIL reset_mid_run: got prod=%h busy=%b done=%b leak=%b sticky=%b spread=%0d cnt=%0d, want all 0",
               product, busy, done, leak, leak_sticky, spread, leak_count);
    end
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    vec++;
    if (saw_done) begin
      fails++;
      $display("FAIL abort_no_done: got done/busy activity after reset, want none");
    end
    prevp[0] = 8'd0; prevp[1] = 8'd0;
    m_sticky = 1'b0; m_cnt = 0; m_leak = 1'b0; m_spread = 0;
    run_check({4'd4, 4'd15}, {4'd15, 4'd2}, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_const_mode();
    test_early_term();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
    $finish;
  end

  // Absolute time bound in case a wait goes wrong
  initial begin
    #200000;
    $display("FAIL timeout: got no completion, want end of test");
    $fatal(1, "timeout");
  end

endmodule
